pipe_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Generates the 2-bit selects for the two EX-stage ALU operand 3-input muxes.
- Detects load-use hazards and sequences the multi-cycle mult/div unit (MDU) with a busy counter.
- Drives PC hold, IF/ID hold and flush, and the ID/EX bubble.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/fwd_sel_unit.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  // Operand mux selects for the EX-stage ALU inputs
  localparam logic [1:0] FWD_IDEX = 2'd0;
  localparam logic [1:0] FWD_WB   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;

  // Hard-wired zero register; never a forwarding source
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Multiply/divide unit sequencing states
  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one EX-stage source operand.
// The younger producer (EX/MEM) wins over the older one (MEM/WB).
module fwd_sel_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_ex_src,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  output logic [1:0]            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Priority compare of the source register against both producers
  always_comb begin
    w_mem_hit = i_mem_reg_write && (i_mem_rd != REG_ADDR_W'(REG_ZERO)) && (i_mem_rd == i_ex_src);
    w_wb_hit  = i_wb_reg_write && (i_wb_rd != REG_ADDR_W'(REG_ZERO)) && (i_wb_rd == i_ex_src);
    o_sel     = FWD_IDEX;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule : fwd_sel_unit

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter ports are tied to zero.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_uses_hilo,
  input  logic                  i_id_is_mdu,
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_mdu_start,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_pc_hold,
  output logic                  o_ifid_hold,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic                  o_mdu_busy,
  output logic                  o_mdu_done,
  output logic                  o_mdu_err,
  output logic [31:0]           o_perf_stall_cnt,
  output logic [31:0]           o_perf_flush_cnt
);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_done;
  logic             w_busy;

  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_lu;
  logic             w_mh;
  logic             w_stall;

  // EX write-enable is implied by ex_mem_read for loads; not needed here
  logic             w_unused;
  assign w_unused = i_ex_reg_write;

  fwd_sel_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_a (
    .i_ex_src       (i_ex_rs),
    .i_mem_rd       (i_mem_rd),
    .i_mem_reg_write(i_mem_reg_write),
    .i_wb_rd        (i_wb_rd),
    .i_wb_reg_write (i_wb_reg_write),
    .o_sel          (w_fwd_a)
  );

  fwd_sel_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_b (
    .i_ex_src       (i_ex_rt),
    .i_mem_rd       (i_mem_rd),
    .i_mem_reg_write(i_mem_reg_write),
    .i_wb_rd        (i_wb_rd),
    .i_wb_reg_write (i_wb_reg_write),
    .o_sel          (w_fwd_b)
  );

  // MDU state, countdown and sticky error registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // MDU next-state; a start while busy is dropped and flagged
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_done      = 1'b0;
    unique case (r_state)
      MDU_IDLE: begin
        if (i_mdu_start) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = CNT_W'(MDU_LATENCY - 1);
        end
      end
      MDU_BUSY: begin
        if (i_mdu_start) begin
          w_err_nxt = 1'b1;
        end
        if (r_cnt == CNT_W'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = MDU_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = MDU_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_busy = (r_state == MDU_BUSY);

  // Load-use and MDU hazards; a taken branch squashes the stalled instruction
  always_comb begin
    w_lu = i_ex_mem_read && (i_ex_rd != REG_ADDR_W'(REG_ZERO)) &&
           ((i_id_uses_rs && (i_ex_rd == i_id_rs)) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
    w_mh    = w_busy && (i_id_uses_hilo || i_id_is_mdu);
    w_stall = (w_lu || w_mh) && !i_ex_branch_taken;
  end

  // Outputs are held inactive while reset is asserted
  always_comb begin
    o_fwd_a_sel   = i_rst_n ? w_fwd_a : FWD_IDEX;
    o_fwd_b_sel   = i_rst_n ? w_fwd_b : FWD_IDEX;
    o_pc_hold     = i_rst_n && w_stall;
    o_ifid_hold   = i_rst_n && w_stall;
    o_ifid_flush  = i_rst_n && i_ex_branch_taken;
    o_idex_bubble = i_rst_n && (w_stall || i_ex_branch_taken);
    o_mdu_busy    = i_rst_n && w_busy;
    o_mdu_done    = i_rst_n && w_done;
    o_mdu_err     = i_rst_n && r_err;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (i_ex_branch_taken) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`else
  assign o_perf_stall_cnt = '0;
  assign o_perf_flush_cnt = '0;
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MDU_LATENCY = 4).
// Build with HAZARD_PERF_CNT_EN defined to exercise the performance counters.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_uses_hilo, id_is_mdu;
  logic       ex_reg_write, ex_mem_read, ex_branch_taken, mdu_start;
  logic       mem_reg_write, wb_reg_write;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic       mdu_busy, mdu_done, mdu_err;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  typedef struct {
    string      name;
    logic [10:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t it;
  int n_cmp;
  int n_err;

  logic [10:0] w_obs;
  assign w_obs = {fwd_a_sel, fwd_b_sel, pc_hold, ifid_hold, ifid_flush, idex_bubble,
                  mdu_busy, mdu_done, mdu_err};

  pipe_hazard_ctrl #(
    .REG_ADDR_W (5),
    .MDU_LATENCY(4),
    .CNT_W      (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_id_rs          (id_rs),
    .i_id_rt          (id_rt),
    .i_id_uses_rs     (id_uses_rs),
    .i_id_uses_rt     (id_uses_rt),
    .i_id_uses_hilo   (id_uses_hilo),
    .i_id_is_mdu      (id_is_mdu),
    .i_ex_rs          (ex_rs),
    .i_ex_rt          (ex_rt),
    .i_ex_rd          (ex_rd),
    .i_ex_reg_write   (ex_reg_write),
    .i_ex_mem_read    (ex_mem_read),
    .i_ex_branch_taken(ex_branch_taken),
    .i_mdu_start      (mdu_start),
    .i_mem_rd         (mem_rd),
    .i_mem_reg_write  (mem_reg_write),
    .i_wb_rd          (wb_rd),
    .i_wb_reg_write   (wb_reg_write),
    .o_fwd_a_sel      (fwd_a_sel),
    .o_fwd_b_sel      (fwd_b_sel),
    .o_pc_hold        (pc_hold),
    .o_ifid_hold      (ifid_hold),
    .o_ifid_flush     (ifid_flush),
    .o_idex_bubble    (idex_bubble),
    .o_mdu_busy       (mdu_busy),
    .o_mdu_done       (mdu_done),
    .o_mdu_err        (mdu_err),
    .o_perf_stall_cnt (perf_stall_cnt),
    .o_perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation vector; hold is duplicated for pc_hold and ifid_hold
  function automatic logic [10:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic hold, input logic flush, input logic bubble,
                                     input logic busy, input logic done, input logic err);
    return {fa, fb, hold, hold, flush, bubble, busy, done, err};
  endfunction

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0; id_is_mdu = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mdu_start = 1'b0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held low with inputs that would otherwise forward, stall and flush
    rst_n = 1'b0;
    idle_inputs();
    mem_reg_write = 1'b1; mem_rd = 5'd8; ex_rs = 5'd8; ex_rt = 5'd8;
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    ex_branch_taken = 1'b1; mdu_start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      it.name = $sformatf("reset_hold_c%0d", c);
      it.exp  = ev(2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
    n_cmp++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_perf: got %h/%h expected 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
    it.name = "post_reset_idle";
    it.exp  = ev(2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    sb.push_back(it);
    @(negedge clk);
    it = sb.pop_front();
    n_cmp++;
    if (w_obs !== it.exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
    end
  endtask

  task automatic test_forwarding();
    logic       t_mw [6] = '{1, 0, 1, 1, 1, 1};
    logic [4:0] t_mrd[6] = '{8, 8, 0, 3, 5, 31};
    logic       t_ww [6] = '{1, 1, 1, 1, 0, 1};
    logic [4:0] t_wrd[6] = '{8, 8, 0, 8, 7, 31};
    logic [4:0] t_rs [6] = '{8, 8, 0, 8, 7, 30};
    logic [4:0] t_rt [6] = '{0, 8, 0, 3, 5, 31};
    logic [1:0] t_fa [6] = '{2, 1, 0, 1, 0, 0};
    logic [1:0] t_fb [6] = '{0, 1, 0, 2, 2, 2};
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      idle_inputs();
      mem_reg_write = t_mw[s]; mem_rd = t_mrd[s];
      wb_reg_write = t_ww[s]; wb_rd = t_wrd[s];
      ex_rs = t_rs[s]; ex_rt = t_rt[s];
      it.name = $sformatf("fwd_step%0d", s);
      it.exp  = ev(t_fa[s], t_fb[s], 0, 0, 0, 0, 0, 0);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
  endtask

  task automatic test_load_use();
    logic       t_mr [6] = '{1, 0, 1, 1, 1, 1};
    logic [4:0] t_rd [6] = '{9, 9, 0, 9, 9, 9};
    logic [4:0] t_irs[6] = '{0, 0, 0, 9, 9, 4};
    logic [4:0] t_irt[6] = '{9, 9, 0, 4, 9, 5};
    logic       t_urs[6] = '{0, 0, 0, 1, 0, 1};
    logic       t_urt[6] = '{1, 1, 1, 0, 0, 1};
    logic       t_st [6] = '{1, 0, 0, 1, 0, 0};
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      idle_inputs();
      ex_mem_read = t_mr[s]; ex_reg_write = t_mr[s]; ex_rd = t_rd[s];
      id_rs = t_irs[s]; id_rt = t_irt[s];
      id_uses_rs = t_urs[s]; id_uses_rt = t_urt[s];
      it.name = $sformatf("load_use_step%0d", s);
      it.exp  = ev(2'd0, 2'd0, t_st[s], 0, t_st[s], 0, 0, 0);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
  endtask

  task automatic test_branch_override();
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      idle_inputs();
      ex_branch_taken = 1'b1;
      if (s == 0) begin
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
      end
      it.name = (s == 0) ? "branch_over_load_use" : "branch_only";
      it.exp  = ev(2'd0, 2'd0, 0, 1, 1, 0, 0, 0);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
  endtask

  task automatic test_mdu_stall();
    // One start pulse; mfhi waiting in ID the whole time
    logic t_busy[5] = '{0, 1, 1, 1, 0};
    logic t_done[5] = '{0, 0, 0, 1, 0};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      id_uses_hilo = 1'b1;
      mdu_start = (c == 0);
      it.name = $sformatf("mdu_stall_c%0d", c);
      it.exp  = ev(2'd0, 2'd0, t_busy[c], 0, t_busy[c], t_busy[c], t_done[c], 0);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
  endtask

  task automatic test_mdu_err_reset();
    // Restart while busy must not reload the count; reset mid-count clears all
    logic t_start[9] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    logic t_rst  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic t_busy [9] = '{0, 1, 1, 1, 0, 0, 1, 0, 0};
    logic t_done [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic t_err  [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      mdu_start = t_start[c];
      rst_n = t_rst[c];
      it.name = $sformatf("mdu_err_c%0d", c);
      it.exp  = ev(2'd0, 2'd0, 0, 0, 0, t_busy[c], t_done[c], t_err[c]);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Start issued under a taken branch, then mult in ID waits on the MDU
    logic [10:0] t_exp[5];
    t_exp[0] = ev(2'd0, 2'd0, 0, 1, 1, 0, 0, 0);
    t_exp[1] = ev(2'd0, 2'd0, 1, 0, 1, 1, 0, 0);
    t_exp[2] = ev(2'd0, 2'd0, 1, 0, 1, 1, 0, 0);
    t_exp[3] = ev(2'd0, 2'd0, 0, 1, 1, 1, 1, 0);
    t_exp[4] = ev(2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      mdu_start = (c == 0);
      ex_branch_taken = (c == 0) || (c == 3);
      id_is_mdu = (c != 0);
      it.name = $sformatf("b2b_c%0d", c);
      it.exp  = t_exp[c];
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      n_cmp++;
      if (w_obs !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", it.name, w_obs, it.exp);
      end
    end
  endtask

  task automatic test_perf();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (c < 5) begin
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
      end else begin
        ex_branch_taken = 1'b1;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if (perf_stall_cnt !== 32'd5) begin
      n_err++;
      $display("FAIL perf_stall: got %0d expected 5", perf_stall_cnt);
    end
    n_cmp++;
    if (perf_flush_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL perf_flush: got %0d expected 2", perf_flush_cnt);
    end
    force dut.r_perf_stall_cnt = 32'hFFFF_FFFF;
    force dut.r_perf_flush_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_stall_cnt;
    release dut.r_perf_flush_cnt;
    @(posedge clk); #1;
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    ex_branch_taken = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL perf_wrap: got %h/%h expected 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`else
    n_cmp++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL perf_tied: got %h/%h expected 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_override();
    test_mdu_stall();
    test_mdu_err_reset();
    test_back_to_back();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_pipe_hazard_ctrl
